// File: rtl/ir_frame_assembler_if.sv
// Bundles the IR frame assembler's signals: the decoder symbol stream, the byte output stream and the frame status.
// The slave modport is the assembler's view; the master modport is the decoder/consumer side.
interface ir_frame_assembler_if #(
  parameter int LEN_W = 6
);
  logic [1:0]       code;
  logic             code_valid;
  logic [7:0]       out_data;
  logic             out_valid;
  logic             out_ready;
  logic             frame_done;
  logic             frame_ok;
  logic [LEN_W-1:0] frame_len;
  logic             overflow;

  modport slave (
    input  code, code_valid, out_ready,
    output out_data, out_valid, frame_done, frame_ok, frame_len, overflow
  );

  modport master (
    output code, code_valid, out_ready,
    input  out_data, out_valid, frame_done, frame_ok, frame_len, overflow
  );
endinterface

// File: rtl/ir_frame_assembler.sv
// Packs IR decoder bits LSB-first into bytes, queues them in a FWFT byte FIFO and checks the HVAC checksum per frame.
// Optional macro IR_FRAME_TERM_EN appends a terminator byte (0x0A ok / 0x21 bad) after each STOP-terminated frame.
module ir_frame_assembler #(
  parameter int FIFO_AW   = 4,
  parameter int MAX_BYTES = 32,
  parameter int LEN_W     = 6
) (
  input  logic               clk,
  input  logic               reset,
  ir_frame_assembler_if.slave bus
);

  localparam int DEPTH = 2 ** FIFO_AW;
  localparam logic [1:0] C_STOP  = 2'b00;
  localparam logic [1:0] C_START = 2'b01;
  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_BYTES);
  localparam logic [FIFO_AW:0] DEPTH_CNT = (FIFO_AW + 1)'(DEPTH);

  typedef enum logic {
    S_IDLE,
    S_DATA
  } state_e;

  state_e           state_q, state_d;
  logic [7:0]       shift_q, shift_d;
  logic [2:0]       bitcnt_q, bitcnt_d;
  logic [LEN_W-1:0] nbytes_q, nbytes_d;
  logic [7:0]       sum_q, sum_d;
  logic [7:0]       last_q, last_d;
  logic             overflow_q, overflow_d;
  logic             done_q, done_d;
  logic             ok_q, ok_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             termPending_q, termPending_d;

  // Completed bytes sit one cycle in this stage before entering the FIFO.
  logic             stValid_q, stValid_d;
  logic [7:0]       stData_q, stData_d;

  logic [7:0]         mem [DEPTH];
  logic [FIFO_AW-1:0] wptr_q, wptr_d;
  logic [FIFO_AW-1:0] rptr_q, rptr_d;
  logic [FIFO_AW:0]   count_q, count_d;

  logic       fifoPop;
  logic       fifoAccept;
  logic       fifoDrop;
  logic       startFrame;
  logic [7:0] newByte;

  assign fifoPop    = (count_q != '0) && bus.out_ready;
  assign fifoAccept = stValid_q && ((count_q < DEPTH_CNT) || fifoPop);
  assign fifoDrop   = stValid_q && !fifoAccept;
  assign newByte    = {bus.code[0], shift_q[7:1]};

  always_comb begin
    state_d       = state_q;
    shift_d       = shift_q;
    bitcnt_d      = bitcnt_q;
    nbytes_d      = nbytes_q;
    sum_d         = sum_q;
    last_d        = last_q;
    overflow_d    = overflow_q | fifoDrop;
    done_d        = 1'b0;
    ok_d          = ok_q;
    len_d         = len_q;
    termPending_d = 1'b0;
    stValid_d     = 1'b0;
    stData_d      = stData_q;
    startFrame    = 1'b0;

`ifdef IR_FRAME_TERM_EN
    if (termPending_q) begin
      stValid_d = 1'b1;
      stData_d  = ok_q ? 8'h0A : 8'h21;
    end
`endif

    if (bus.code_valid) begin
      case (state_q)
        S_IDLE: begin
          if (bus.code == C_START) startFrame = 1'b1;
        end
        S_DATA: begin
          if (bus.code[1]) begin
            shift_d  = newByte;
            bitcnt_d = bitcnt_q + 3'd1;
            if (bitcnt_q == 3'd7) begin
              if (nbytes_q < MAX_LEN) begin
                stValid_d = 1'b1;
                stData_d  = newByte;
              end
              if (nbytes_q <= MAX_LEN) nbytes_d = nbytes_q + 1'b1;
              if (nbytes_q != '0) sum_d = sum_q + last_q;
              last_d = newByte;
            end
          end else if (bus.code == C_STOP) begin
            // A byte being dropped this very cycle still spoils the frame.
            done_d  = 1'b1;
            ok_d    = (nbytes_q >= LEN_W'(2)) && (nbytes_q <= MAX_LEN) &&
                      (bitcnt_q == 3'd0) && !(overflow_q || fifoDrop) &&
                      (last_q == sum_q);
            len_d   = (nbytes_q > MAX_LEN) ? MAX_LEN : nbytes_q;
            state_d = S_IDLE;
`ifdef IR_FRAME_TERM_EN
            termPending_d = 1'b1;
`endif
          end else begin
            done_d     = 1'b1;
            ok_d       = 1'b0;
            len_d      = (nbytes_q > MAX_LEN) ? MAX_LEN : nbytes_q;
            startFrame = 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    if (startFrame) begin
      state_d    = S_DATA;
      shift_d    = 8'h00;
      bitcnt_d   = 3'd0;
      nbytes_d   = '0;
      sum_d      = 8'h00;
      last_d     = 8'h00;
      overflow_d = 1'b0;
    end
  end

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (fifoAccept) wptr_d = wptr_q + 1'b1;
    if (fifoPop) rptr_d = rptr_q + 1'b1;
    if (fifoAccept && !fifoPop) count_d = count_q + 1'b1;
    else if (!fifoAccept && fifoPop) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      shift_q       <= 8'h00;
      bitcnt_q      <= 3'd0;
      nbytes_q      <= '0;
      sum_q         <= 8'h00;
      last_q        <= 8'h00;
      overflow_q    <= 1'b0;
      done_q        <= 1'b0;
      ok_q          <= 1'b0;
      len_q         <= '0;
      termPending_q <= 1'b0;
      stValid_q     <= 1'b0;
      stData_q      <= 8'h00;
      wptr_q        <= '0;
      rptr_q        <= '0;
      count_q       <= '0;
    end else begin
      state_q       <= state_d;
      shift_q       <= shift_d;
      bitcnt_q      <= bitcnt_d;
      nbytes_q      <= nbytes_d;
      sum_q         <= sum_d;
      last_q        <= last_d;
      overflow_q    <= overflow_d;
      done_q        <= done_d;
      ok_q          <= ok_d;
      len_q         <= len_d;
      termPending_q <= termPending_d;
      stValid_q     <= stValid_d;
      stData_q      <= stData_d;
      wptr_q        <= wptr_d;
      rptr_q        <= rptr_d;
      count_q       <= count_d;
    end
  end

  // Storage needs no reset; count_q alone decides what is visible.
  always_ff @(posedge clk) begin
    if (fifoAccept) mem[wptr_q] <= stData_q;
  end

  assign bus.out_valid  = (count_q != '0);
  assign bus.out_data   = (count_q != '0) ? mem[rptr_q] : 8'h00;
  assign bus.frame_done = done_q;
  assign bus.frame_ok   = ok_q;
  assign bus.frame_len  = len_q;
  assign bus.overflow   = overflow_q;

endmodule

// File: tb/tb_ir_frame_assembler.sv
// Directed self-checking bench for ir_frame_assembler: hand-computed byte and frame-status queues checked by monitors.
// Builds with or without IR_FRAME_TERM_EN; terminator expectations follow the macro.
module tb_ir_frame_assembler;

  localparam logic [1:0] C_STOP  = 2'b00;
  localparam logic [1:0] C_START = 2'b01;
  localparam logic [1:0] C_ZERO  = 2'b10;
  localparam logic [1:0] C_ONE   = 2'b11;

  logic clk;
  logic reset;
  int   testsRun;
  int   testsFailed;
  int   extraBytes;
  int   extraFrames;
  logic [7:0] expQ [$];
  int         expFrames [$];

  ir_frame_assembler_if #(.LEN_W(6)) bus ();

  ir_frame_assembler #(
    .FIFO_AW  (4),
    .MAX_BYTES(32),
    .LEN_W    (6)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] c);
    bus.code       = c;
    bus.code_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.code_valid = 1'b0;
  endtask

  task automatic sendByte(input logic [7:0] b);
    for (int i = 0; i < 8; i++) applyStimulus(b[i] ? C_ONE : C_ZERO);
  endtask

  task automatic idleCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic waitDrain(input string tag);
    for (int i = 0; i < 300 && (expQ.size() != 0 || expFrames.size() != 0); i++) @(posedge clk);
    idleCycles(4);
    checkOutput({tag, ".pending"}, expQ.size() + expFrames.size(), 0);
    checkOutput({tag, ".extraBytes"}, extraBytes, 0);
    checkOutput({tag, ".extraFrames"}, extraFrames, 0);
  endtask

  task automatic expectTerm(input logic ok);
`ifdef IR_FRAME_TERM_EN
    expQ.push_back(ok ? 8'h0A : 8'h21);
`else
    if (ok) begin end
`endif
  endtask

  // Output bytes and frame status are sampled mid-cycle against the expectation queues.
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.out_valid && bus.out_ready) begin
        if (expQ.size() == 0) extraBytes++;
        else checkOutput("outByte", {24'd0, bus.out_data}, {24'd0, expQ.pop_front()});
      end
      if (bus.frame_done) begin
        if (expFrames.size() == 0) extraFrames++;
        else begin
          int e;
          e = expFrames.pop_front();
          checkOutput("frameOk", {31'd0, bus.frame_ok}, 32'(e / 256));
          checkOutput("frameLen", {26'd0, bus.frame_len}, 32'(e % 256));
        end
      end
    end
  end

  initial begin
    testsRun       = 0;
    testsFailed    = 0;
    extraBytes     = 0;
    extraFrames    = 0;
    reset          = 1'b1;
    bus.code       = C_STOP;
    bus.code_valid = 1'b0;
    bus.out_ready  = 1'b0;
    idleCycles(2);
    checkOutput("rst.outValid", {31'd0, bus.out_valid}, 0);
    checkOutput("rst.outData", {24'd0, bus.out_data}, 0);
    checkOutput("rst.frameDone", {31'd0, bus.frame_done}, 0);
    checkOutput("rst.frameOk", {31'd0, bus.frame_ok}, 0);
    checkOutput("rst.frameLen", {26'd0, bus.frame_len}, 0);
    checkOutput("rst.overflow", {31'd0, bus.overflow}, 0);
    reset = 1'b0;
    idleCycles(1);

    // Clean frame: 0x11 + 0x22 == 0x33
    bus.out_ready = 1'b1;
    expQ.push_back(8'h11); expQ.push_back(8'h22); expQ.push_back(8'h33);
    expectTerm(1'b1);
    expFrames.push_back(256 + 3);
    applyStimulus(C_START);
    sendByte(8'h11); sendByte(8'h22); sendByte(8'h33);
    applyStimulus(C_STOP);
    checkOutput("clean.doneLatency", {31'd0, bus.frame_done}, 1);
    idleCycles(1);
    checkOutput("clean.donePulse", {31'd0, bus.frame_done}, 0);
    waitDrain("clean");
    checkOutput("clean.overflow", {31'd0, bus.overflow}, 0);

    // Bad checksum
    expQ.push_back(8'h11); expQ.push_back(8'h22); expQ.push_back(8'h34);
    expectTerm(1'b0);
    expFrames.push_back(3);
    applyStimulus(C_START);
    sendByte(8'h11); sendByte(8'h22); sendByte(8'h34);
    applyStimulus(C_STOP);
    waitDrain("badSum");

    // Partial trailing byte
    expQ.push_back(8'h11); expQ.push_back(8'h22); expQ.push_back(8'h33);
    expectTerm(1'b0);
    expFrames.push_back(3);
    applyStimulus(C_START);
    sendByte(8'h11); sendByte(8'h22); sendByte(8'h33);
    applyStimulus(C_ONE); applyStimulus(C_ZERO); applyStimulus(C_ONE);
    applyStimulus(C_ZERO); applyStimulus(C_ONE);
    applyStimulus(C_STOP);
    waitDrain("partial");

    // Preamble ignored in IDLE, then an aborted frame followed by a good one
    applyStimulus(C_ONE); applyStimulus(C_ZERO); applyStimulus(C_STOP);
    idleCycles(4);
    checkOutput("preamble.outValid", {31'd0, bus.out_valid}, 0);
    checkOutput("preamble.extraFrames", extraFrames, 0);
    expQ.push_back(8'hAA); expQ.push_back(8'h05); expQ.push_back(8'h02); expQ.push_back(8'h07);
    expectTerm(1'b1);
    expFrames.push_back(1);
    expFrames.push_back(256 + 3);
    applyStimulus(C_START);
    sendByte(8'hAA);
    applyStimulus(C_START);
    sendByte(8'h05); sendByte(8'h02); sendByte(8'h07);
    applyStimulus(C_STOP);
    waitDrain("abort");

    // Overflow: 17 bytes into a 16-deep FIFO with the consumer stalled
    bus.out_ready = 1'b0;
    for (int i = 0; i < 16; i++) expQ.push_back(8'(i));
    expFrames.push_back(17);
    applyStimulus(C_START);
    for (int i = 0; i < 17; i++) sendByte(8'(i));
    idleCycles(1);
    checkOutput("ovf.outValid", {31'd0, bus.out_valid}, 1);
    checkOutput("ovf.overflow", {31'd0, bus.overflow}, 1);
    applyStimulus(C_STOP);
    idleCycles(4);
    bus.out_ready = 1'b1;
    waitDrain("ovf");
    checkOutput("ovf.drainedEmpty", {31'd0, bus.out_valid}, 0);
    checkOutput("ovf.sticky", {31'd0, bus.overflow}, 1);
    applyStimulus(C_START);
    checkOutput("ovf.clearOnStart", {31'd0, bus.overflow}, 0);
    expectTerm(1'b0);
    expFrames.push_back(0);
    applyStimulus(C_STOP);
    waitDrain("emptyFrame");

    // Full FIFO: push and pop in the same cycle, then reset with bytes queued
    bus.out_ready = 1'b0;
    for (int i = 0; i < 17; i++) expQ.push_back(8'h40 + 8'(i));
    applyStimulus(C_START);
    sendByte(8'h40);
    checkOutput("fwft.notYet", {31'd0, bus.out_valid}, 0);
    idleCycles(1);
    checkOutput("fwft.valid", {31'd0, bus.out_valid}, 1);
    checkOutput("fwft.head", {24'd0, bus.out_data}, 32'h40);
    for (int i = 1; i < 16; i++) sendByte(8'h40 + 8'(i));
    sendByte(8'h50);
    bus.out_ready = 1'b1;
    idleCycles(1);
    bus.out_ready = 1'b0;
    idleCycles(1);
    checkOutput("full.pushPopOverflow", {31'd0, bus.overflow}, 0);
    checkOutput("full.head", {24'd0, bus.out_data}, 32'h41);
    sendByte(8'h51);
    idleCycles(1);
    checkOutput("full.stillFull", {31'd0, bus.overflow}, 1);
    reset = 1'b1;
    idleCycles(1);
    expQ.delete();
    expFrames.delete();
    checkOutput("midRst.outValid", {31'd0, bus.out_valid}, 0);
    checkOutput("midRst.outData", {24'd0, bus.out_data}, 0);
    checkOutput("midRst.overflow", {31'd0, bus.overflow}, 0);
    reset = 1'b0;
    bus.out_ready = 1'b1;
    idleCycles(4);
    checkOutput("midRst.noBytes", extraBytes, 0);

    // Clean frame after reset proves pointers and state restarted
    expQ.push_back(8'h05); expQ.push_back(8'h02); expQ.push_back(8'h07);
    expectTerm(1'b1);
    expFrames.push_back(256 + 3);
    applyStimulus(C_START);
    sendByte(8'h05); sendByte(8'h02); sendByte(8'h07);
    applyStimulus(C_STOP);
    waitDrain("postRst");

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
